// File: rtl/des_sbox_seq.sv
// Sequential DES S-box substitution: evaluates S1..S8 over 8/LANES cycles and
// returns the 32-bit pre-permutation result over a valid/ready handshake.

module nbit_mux #(
  parameter int DATA_SIZE = 6
) (
  input  logic [(2**DATA_SIZE)-1:0] data,
  input  logic [DATA_SIZE-1:0]      sel,
  output logic                      y
);
  assign y = data[sel];
endmodule

module des_sbox_seq #(
  parameter int LANES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);
  // state | meaning
  // IDLE  | waiting for an input transfer
  // RUN   | evaluating LANES S-boxes per cycle
  // DONE  | result held until downstream accepts

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : gBadLanes
    $error("des_sbox_seq: LANES must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  // S-boxes in row-major order: nibble (row*16+col) sits at [255-4*(row*16+col) -: 4].
  function automatic logic [255:0] sboxTable(input int box);
    case (box)
      0:       sboxTable = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
      1:       sboxTable = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
      2:       sboxTable = 256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
      3:       sboxTable = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
      4:       sboxTable = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
      5:       sboxTable = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
      6:       sboxTable = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
      default: sboxTable = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    endcase
  endfunction

  // One output bit of one S-box, re-ordered so the raw 6-bit group is the mux select.
  function automatic logic [63:0] rawColumn(input int box, input int bitIdx);
    logic [255:0] tbl;
    logic [5:0]   b;
    int           pos;
    rawColumn = '0;
    tbl = sboxTable(box);
    for (int idx = 0; idx < 64; idx++) begin
      b = 6'(idx);
      pos = 4 * (int'({b[5], b[0]}) * 16 + int'(b[4:1]));
      rawColumn[idx] = tbl[252 - pos + bitIdx];
    end
  endfunction

  stateT       state, stateNext;
  logic [2:0]  grp;
  logic [47:0] dinQ;
  logic        lastGrp;
  logic        accept;

  logic [63:0] tblBits [8][4];
  logic [2:0]  laneBox [LANES];
  logic [5:0]  laneSel [LANES];
  logic [3:0]  laneNib [LANES];

  for (genvar bx = 0; bx < 8; bx++) begin : gBox
    for (genvar bt = 0; bt < 4; bt++) begin : gBit
      localparam logic [63:0] COL = rawColumn(bx, bt);
      assign tblBits[bx][bt] = COL;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : gLane
    assign laneBox[l] = grp + 3'(l);
    assign laneSel[l] = dinQ[47 - 6 * int'(laneBox[l]) -: 6];
    for (genvar bt = 0; bt < 4; bt++) begin : gBit
      nbit_mux #(.DATA_SIZE(6)) uMux (
        .data (tblBits[laneBox[l]][bt]),
        .sel  (laneSel[l]),
        .y    (laneNib[l][bt])
      );
    end
  end

  assign lastGrp   = ({1'b0, grp} + 4'(LANES)) == 4'd8;
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = RUN;
      RUN:     if (lastGrp) stateNext = DONE;
      DONE:    if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grp      <= '0;
      dinQ     <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dinQ     <= in_data;
            grp      <= '0;
            out_data <= '0;
          end
        end
        RUN: begin
          for (int l = 0; l < LANES; l++) begin
            out_data[31 - 4 * int'(laneBox[l]) -: 4] <= laneNib[l];
          end
          grp <= grp + 3'(LANES);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_des_sbox_seq.sv
// Bench for des_sbox_seq: one instance per legal LANES value, directed cases
// plus a randomized handshake sweep against a row/column S-box model.

module tb_des_sbox_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        inValid  [4];
  logic        inReady  [4];
  logic [47:0] inData   [4];
  logic        outValid [4];
  logic        outReady [4];
  logic [31:0] outData  [4];
  logic        busy     [4];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : gDut
    des_sbox_seq #(.LANES(1 << g)) uDut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid[g]),
      .in_ready  (inReady[g]),
      .in_data   (inData[g]),
      .out_valid (outValid[g]),
      .out_ready (outReady[g]),
      .out_data  (outData[g]),
      .busy      (busy[g])
    );
  end

  // FIPS 46-3 S-boxes, each row written left to right, rows 0..3.
  function automatic logic [255:0] sboxRows(input int k);
    case (k)
      0:       sboxRows = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
      1:       sboxRows = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
      2:       sboxRows = 256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
      3:       sboxRows = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
      4:       sboxRows = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
      5:       sboxRows = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
      6:       sboxRows = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
      default: sboxRows = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    endcase
  endfunction

  function automatic logic [31:0] refSbox(input logic [47:0] x);
    logic [31:0]  r;
    logic [255:0] t;
    int six, row, col;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      six = int'((x >> (42 - 6 * k)) & 48'h3F);
      row = (six / 32) * 2 + (six % 2);
      col = (six / 2) % 16;
      t = sboxRows(k);
      r = (r << 4) | 32'((t >> (4 * (63 - (row * 16 + col)))) & 256'hF);
    end
    return r;
  endfunction

  task automatic idleAll();
    for (int d = 0; d < 4; d++) begin
      inValid[d]  = 1'b0;
      inData[d]   = '0;
      outReady[d] = 1'b0;
    end
  endtask

  // Presents v until taken; returns at the falling edge right after the accepting edge.
  task automatic sendIn(input int d, input logic [47:0] v, output bit ok);
    ok = 1'b0;
    inValid[d] = 1'b1;
    inData[d]  = v;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (inReady[d] === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    inValid[d] = 1'b0;
  endtask

  task automatic waitOut(input int d, output int cyc);
    cyc = 0;
    while (outValid[d] !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (outValid[d] !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    idleAll();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (inReady[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_in_ready dut%0d: got %b want 0", d, inReady[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({outValid[d], busy[d], inReady[d]} !== 3'b001 || outData[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d: valid/busy/ready=%b%b%b data=%h want 001 00000000",
                 d, outValid[d], busy[d], inReady[d], outData[d]);
      end
    end
  endtask

  task automatic test_single(input string name, input int d, input logic [47:0] v,
                             input logic [31:0] exp);
    bit ok;
    int n;
    n = 8 >> d;
    sendIn(d, v, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_accept dut%0d: in_ready never rose", name, d);
      return;
    end
    for (int c = 0; c <= n; c++) begin
      checks++;
      if (outValid[d] !== (c == n) || inReady[d] !== 1'b0 || busy[d] !== 1'b1) begin
        errors++;
        $display("FAIL %s_timing dut%0d cycle %0d: valid/ready/busy=%b%b%b want %b01",
                 name, d, c, outValid[d], inReady[d], busy[d], (c == n));
      end
      if (c < n) @(negedge clk);
    end
    checks++;
    if (outData[d] !== exp) begin
      errors++;
      $display("FAIL %s_data dut%0d: got %h want %h", name, d, outData[d], exp);
    end
    outReady[d] = 1'b1;
    @(negedge clk);
    outReady[d] = 1'b0;
    checks++;
    if (outValid[d] !== 1'b0 || inReady[d] !== 1'b1 || busy[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s_release dut%0d: valid/ready/busy=%b%b%b want 010",
               name, d, outValid[d], inReady[d], busy[d]);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    logic [47:0] a, b;
    a = {16'($urandom()), 32'($urandom())};
    b = ~a;
    sendIn(0, a, ok);
    waitOut(0, cyc);
    checks++;
    if (!ok || cyc != 8) begin
      errors++;
      $display("FAIL bp_first_latency: accepted=%0d latency=%0d want 1 and 8", ok, cyc);
    end
    inValid[0] = 1'b1;
    inData[0]  = b;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (outValid[0] !== 1'b1 || inReady[0] !== 1'b0 || outData[0] !== refSbox(a)) begin
        errors++;
        $display("FAIL bp_stall cycle %0d: valid=%b ready=%b data=%h want 1 0 %h",
                 i, outValid[0], inReady[0], outData[0], refSbox(a));
      end
    end
    outReady[0] = 1'b1;
    @(negedge clk);
    outReady[0] = 1'b0;
    checks++;
    if (outValid[0] !== 1'b0 || inReady[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b want 0 1", outValid[0], inReady[0]);
    end
    @(negedge clk);
    inValid[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b1 || inReady[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_accept: busy=%b ready=%b want 1 0", busy[0], inReady[0]);
    end
    waitOut(0, cyc);
    checks++;
    if (cyc != 8 || outData[0] !== refSbox(b)) begin
      errors++;
      $display("FAIL bp_second: latency=%0d data=%h want 8 %h", cyc, outData[0], refSbox(b));
    end
    outReady[0] = 1'b1;
    @(negedge clk);
    outReady[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    sendIn(0, 48'h123456789ABC, ok);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (outValid[0] !== 1'b0 || outData[0] !== 32'h0 || busy[0] !== 1'b0 || inReady[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: valid=%b data=%h busy=%b ready=%b want 0 00000000 0 0",
               outValid[0], outData[0], busy[0], inReady[0]);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (outValid[0] !== 1'b0 || inReady[0] !== 1'b1) begin
        errors++;
        $display("FAIL midrst_no_output: valid=%b ready=%b want 0 1", outValid[0], inReady[0]);
      end
    end
    sendIn(0, 48'h0, ok);
    waitOut(0, cyc);
    checks++;
    if (!ok || cyc != 8 || outData[0] !== 32'hEFA72C4D) begin
      errors++;
      $display("FAIL midrst_fresh: accepted=%0d latency=%0d data=%h want 1 8 efa72c4d",
               ok, cyc, outData[0]);
    end
    outReady[0] = 1'b1;
    @(negedge clk);
    outReady[0] = 1'b0;
  endtask

  task automatic test_random(input int d, input int n);
    logic [31:0] expQ[$];
    logic [31:0] exp;
    int sent, got, cyc;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < n && cyc < n * 30) begin
      inValid[d]  = (sent < n) && ($urandom_range(0, 3) != 0);
      inData[d]   = {16'($urandom()), 32'($urandom())};
      outReady[d] = ($urandom_range(0, 2) != 0);
      if (inValid[d] && inReady[d] === 1'b1) begin
        expQ.push_back(refSbox(inData[d]));
        sent++;
      end
      if (outValid[d] === 1'b1 && outReady[d]) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL rand_extra dut%0d: output %h with nothing outstanding", d, outData[d]);
        end else begin
          exp = expQ.pop_front();
          if (outData[d] !== exp) begin
            errors++;
            $display("FAIL rand_data dut%0d item %0d: got %h want %h", d, got, outData[d], exp);
          end
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    inValid[d]  = 1'b0;
    outReady[d] = 1'b0;
    checks++;
    if (got != n || expQ.size() != 0) begin
      errors++;
      $display("FAIL rand_count dut%0d: outputs=%0d pending=%0d want %0d 0", d, got, expQ.size(), n);
    end
  endtask

  initial begin
    test_reset();
    test_single("zero_l1", 0, 48'h000000000000, 32'hEFA72C4D);
    test_single("ones_l8", 3, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB);
    for (int d = 0; d < 3; d++) test_single("rowcol", d, 48'h6C0000000000, 32'h5FA72C4D);
    test_backpressure();
    test_reset_mid();
    test_random(0, 1000);
    test_random(1, 200);
    test_random(2, 200);
    test_random(3, 200);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
